mux_rr_nw: RTL

Parametrised N-channel, W-bit registered multiplexer with valid/ready handshakes and round-robin arbitration, the next generation of the fixed 8:1 32-bit select mux. It merges N producer streams into one consumer stream, e.g. writeback sources feeding a single register-file write port. A forced-select mode keeps the old explicit-select behaviour available. The output is registered: one cycle of latency and full one-beat-per-cycle throughput.

---
 rtl/mux_rr_nw.sv | 102 ++++++++++
 1 files changed

// File: rtl/mux_rr_nw.sv
// N-channel, W-bit registered valid/ready multiplexer with round-robin or forced-select arbitration.
// Optional packet locking (grant held until in_last) is enabled by defining MUX_RR_LOCK_EN.
module mux_rr_nw #(
   parameter int W = 32,
   parameter int N = 8,
   localparam int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
`ifdef MUX_RR_LOCK_EN
   input  logic [N-1:0]    in_last,
`endif
   input  logic            force_en,
   input  logic [SW-1:0]   force_sel,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_sel,
   output logic            out_last,
   output logic            out_valid,
   input  logic            out_ready
);

   logic [SW-1:0] ptr;
   logic [SW-1:0] grant_idx;
   logic [SW-1:0] rr_cand;
   logic          grant_valid;
   logic          can_load;
   logic          accept;
   logic          lock;

   assign can_load = !out_valid || out_ready;
   assign accept   = grant_valid && can_load && !rst;

   // Search starts just after the last granted channel, so the previous winner has lowest priority.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = ptr;
      rr_cand     = ptr;
      if (lock) begin
         grant_valid = in_valid[ptr];
      end else if (force_en) begin
         if (int'(force_sel) < N) begin
            if (in_valid[force_sel]) begin
               grant_valid = 1'b1;
               grant_idx   = force_sel;
            end
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            rr_cand = SW'((int'(ptr) + k) % N);
            if (!grant_valid && in_valid[rr_cand]) begin
               grant_valid = 1'b1;
               grant_idx   = rr_cand;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_valid && (grant_idx == SW'(i)) && can_load && !rst) begin
            in_ready[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= SW'(N - 1);
      end else if (accept) begin
         out_valid <= 1'b1;
         out_data  <= in_data[int'(grant_idx)*W +: W];
         out_sel   <= grant_idx;
         ptr       <= grant_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef MUX_RR_LOCK_EN
   // A beat without in_last opens a packet; the grant then stays on ptr until its last beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock     <= 1'b0;
         out_last <= 1'b0;
      end else if (accept) begin
         lock     <= !in_last[grant_idx];
         out_last <= in_last[grant_idx];
      end
   end
`else
   assign lock     = 1'b0;
   assign out_last = 1'b0;
`endif

endmodule
